// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter.
//   - default widths and FIFO depth for the integer writeback path
//   - wb_req_t: one completed result (destination register + value)
//   - grant_e:  which source won the register-file write port
package wb_pkg;

    localparam int WB_DATA_WIDTH  = 64;
    localparam int WB_ADDR_WIDTH  = 5;
    localparam int WB_FIFO_DEPTH  = 2;
    localparam int WB_COUNT_WIDTH = $clog2(WB_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of wb_req_t used to buffer load results.
// Ports:
//   i_clk, i_arst_n   clock, asynchronous active-low reset
//   push, push_data   write request (ignored when full)
//   pop               read request (ignored when empty)
//   head              entry at the read pointer
//   full, empty       derived from the registered occupancy count
//   count             occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             push,
    input  wb_req_t          push_data,
    input  logic             pop,
    output wb_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter for the single integer register-file write port.
// Ports:
//   i_clk, i_arst_n                          clock, asynchronous active-low reset
//   i_alu_valid/o_alu_ready/i_alu_rd/i_alu_data  ALU results, unbuffered
//   i_mem_valid/o_mem_ready/i_mem_rd/i_mem_data  load results, pushed into wb_fifo
//   o_write_en_3/o_addr_3/o_write_data_3     registered register-file write
//   o_mem_count                              load FIFO occupancy
// Handshake: a transfer happens on a rising edge where valid && ready.
// Producers keep valid independent of ready and hold rd/data stable
// while valid && !ready. o_mem_ready comes from registered state only;
// o_alu_ready is the combinational ALU grant.
// Arbitration is round-robin between the ALU and a non-empty FIFO; on a
// tie the source that did not win last time wins. The grant order is the
// architectural write order. Results for x0 are consumed but never write.
// The request struct takes its field widths from wb_pkg, so DATA_WIDTH and
// ADDR_WIDTH are expected to stay at the package defaults.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic                         i_alu_valid,
    output logic                         o_alu_ready,
    input  logic [ADDR_WIDTH-1:0]        i_alu_rd,
    input  logic [DATA_WIDTH-1:0]        i_alu_data,
    input  logic                         i_mem_valid,
    output logic                         o_mem_ready,
    input  logic [ADDR_WIDTH-1:0]        i_mem_rd,
    input  logic [DATA_WIDTH-1:0]        i_mem_data,
    output logic                         o_write_en_3,
    output logic [ADDR_WIDTH-1:0]        o_addr_3,
    output logic [DATA_WIDTH-1:0]        o_write_data_3,
    output logic [$clog2(FIFO_DEPTH):0]  o_mem_count
);

    wb_req_t alu_req_d;
    wb_req_t mem_req_d;
    wb_req_t fifo_head;
    wb_req_t winner;
    logic    fifo_full;
    logic    fifo_empty;
    logic    alu_req;
    logic    mem_req;
    logic    grant_alu;
    logic    grant_mem;
    grant_e  last_grant_q;

    assign alu_req_d.rd   = i_alu_rd;
    assign alu_req_d.data = i_alu_data;
    assign mem_req_d.rd   = i_mem_rd;
    assign mem_req_d.data = i_mem_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .push      (i_mem_valid),
        .push_data (mem_req_d),
        .pop       (grant_mem),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_mem_count)
    );

    assign o_mem_ready = !fifo_full;

    // Gating with the reset keeps o_alu_ready low while reset is held,
    // when the FIFO is empty and the ALU would otherwise win.
    assign alu_req = i_alu_valid && i_arst_n;
    assign mem_req = !fifo_empty;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_req && mem_req) begin
            if (last_grant_q == GRANT_MEM) grant_alu = 1'b1;
            else                           grant_mem = 1'b1;
        end else begin
            grant_alu = alu_req;
            grant_mem = mem_req;
        end
    end

    assign o_alu_ready = grant_alu;
    assign winner      = grant_mem ? fifo_head : alu_req_d;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            last_grant_q   <= GRANT_MEM;
            o_write_en_3   <= 1'b0;
            o_addr_3       <= '0;
            o_write_data_3 <= '0;
        end else begin
            o_write_en_3 <= 1'b0;
            if (grant_alu || grant_mem) begin
                last_grant_q   <= grant_mem ? GRANT_MEM : GRANT_ALU;
                o_write_en_3   <= (winner.rd != '0);
                o_addr_3       <= winner.rd;
                o_write_data_3 <= winner.data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a per-cycle vector table covering
// contention, a full FIFO, x0 results and back-to-back loads, followed by
// a hand-written mid-stream reset sequence. A write-order scoreboard
// watches every presented write on the falling edge.
module tb_writeback_arbiter;

    logic        clk;
    logic        i_arst_n;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [63:0] i_alu_data;
    logic        i_mem_valid;
    logic        o_mem_ready;
    logic [4:0]  i_mem_rd;
    logic [63:0] i_mem_data;
    logic        o_write_en_3;
    logic [4:0]  o_addr_3;
    logic [63:0] o_write_data_3;
    logic [1:0]  o_mem_count;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [63:0] mdat;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[18];

    writeback_arbiter dut (
        .i_clk          (clk),
        .i_arst_n       (i_arst_n),
        .i_alu_valid    (i_alu_valid),
        .o_alu_ready    (o_alu_ready),
        .i_alu_rd       (i_alu_rd),
        .i_alu_data     (i_alu_data),
        .i_mem_valid    (i_mem_valid),
        .o_mem_ready    (o_mem_ready),
        .i_mem_rd       (i_mem_rd),
        .i_mem_data     (i_mem_data),
        .o_write_en_3   (o_write_en_3),
        .o_addr_3       (o_addr_3),
        .o_write_data_3 (o_write_data_3),
        .o_mem_count    (o_mem_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [63:0] mdat);
        i_alu_valid = av;
        i_alu_rd    = ard;
        i_alu_data  = adat;
        i_mem_valid = mv;
        i_mem_rd    = mrd;
        i_mem_data  = mdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every presented write must match the next expected address
    always @(negedge clk) begin
        if (i_arst_n === 1'b1 && o_write_en_3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_spurious_write: got addr %0d expected no write", o_addr_3);
            end else begin
                check("sb_write_order", {59'd0, o_addr_3}, {59'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        //            av ard  adat          mv mrd mdat     ar mr we addr data          cnt
        vecs[0]  = '{0, 0,  64'h0,        1, 1,  64'h101, 0, 1, 0, 0,  64'h0,        2'd1};
        vecs[1]  = '{1, 7,  64'hA07,      1, 2,  64'h102, 1, 1, 1, 7,  64'hA07,      2'd2};
        vecs[2]  = '{1, 8,  64'hA08,      0, 0,  64'h0,   0, 0, 1, 1,  64'h101,      2'd1};
        vecs[3]  = '{1, 8,  64'hA08,      1, 3,  64'h103, 1, 1, 1, 8,  64'hA08,      2'd2};
        vecs[4]  = '{1, 9,  64'hA09,      0, 0,  64'h0,   0, 0, 1, 2,  64'h102,      2'd1};
        vecs[5]  = '{1, 9,  64'hA09,      0, 0,  64'h0,   1, 1, 1, 9,  64'hA09,      2'd1};
        vecs[6]  = '{0, 0,  64'h0,        0, 0,  64'h0,   0, 1, 1, 3,  64'h103,      2'd0};
        vecs[7]  = '{1, 5,  64'hDEADBEEF, 0, 0,  64'h0,   1, 1, 1, 5,  64'hDEADBEEF, 2'd0};
        vecs[8]  = '{0, 0,  64'h0,        0, 0,  64'h0,   0, 1, 0, 5,  64'hDEADBEEF, 2'd0};
        vecs[9]  = '{1, 0,  64'h1234,     0, 0,  64'h0,   1, 1, 0, 0,  64'h1234,     2'd0};
        vecs[10] = '{0, 0,  64'h0,        1, 0,  64'h5555,0, 1, 0, 0,  64'h1234,     2'd1};
        vecs[11] = '{0, 0,  64'h0,        0, 0,  64'h0,   0, 1, 0, 0,  64'h5555,     2'd0};
        vecs[12] = '{0, 0,  64'h0,        1, 10, 64'h10A, 0, 1, 0, 0,  64'h5555,     2'd1};
        vecs[13] = '{0, 0,  64'h0,        1, 11, 64'h10B, 0, 1, 1, 10, 64'h10A,      2'd1};
        vecs[14] = '{0, 0,  64'h0,        1, 12, 64'h10C, 0, 1, 1, 11, 64'h10B,      2'd1};
        vecs[15] = '{0, 0,  64'h0,        1, 13, 64'h10D, 0, 1, 1, 12, 64'h10C,      2'd1};
        vecs[16] = '{0, 0,  64'h0,        0, 0,  64'h0,   0, 1, 1, 13, 64'h10D,      2'd0};
        vecs[17] = '{0, 0,  64'h0,        0, 0,  64'h0,   0, 1, 0, 13, 64'h10D,      2'd0};

        exp_q = '{5'd7, 5'd1, 5'd8, 5'd2, 5'd9, 5'd3, 5'd5,
                  5'd10, 5'd11, 5'd12, 5'd13, 5'd22, 5'd20, 5'd6};

        // reset with an ALU result pending: ready must stay low
        i_arst_n = 1'b0;
        drive(1, 5'd3, 64'hA03, 0, 0, 64'h0);
        #2;
        check("rst_alu_ready", {63'd0, o_alu_ready}, 64'd0);
        check("rst_mem_ready", {63'd0, o_mem_ready}, 64'd1);
        check("rst_we",        {63'd0, o_write_en_3}, 64'd0);
        check("rst_addr",      {59'd0, o_addr_3}, 64'd0);
        check("rst_data",      o_write_data_3, 64'd0);
        check("rst_count",     {62'd0, o_mem_count}, 64'd0);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 0, 64'h0);
        i_arst_n = 1'b1;
        tick();

        // table-driven vectors, one per cycle
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
            #1;
            check($sformatf("v%0d_alu_ready", i), {63'd0, o_alu_ready}, {63'd0, vecs[i].e_ar});
            check($sformatf("v%0d_mem_ready", i), {63'd0, o_mem_ready}, {63'd0, vecs[i].e_mr});
            tick();
            check($sformatf("v%0d_we", i),    {63'd0, o_write_en_3}, {63'd0, vecs[i].e_we});
            check($sformatf("v%0d_addr", i),  {59'd0, o_addr_3}, {59'd0, vecs[i].e_addr});
            check($sformatf("v%0d_data", i),  o_write_data_3, vecs[i].e_data);
            check($sformatf("v%0d_count", i), {62'd0, o_mem_count}, {62'd0, vecs[i].e_cnt});
        end

        // mid-stream reset with two loads buffered
        drive(1, 5'd22, 64'hA22, 1, 5'd20, 64'h120);   // ALU 22 wins, FIFO 1
        tick();
        drive(1, 5'd23, 64'hA23, 1, 5'd21, 64'h121);   // load 20 wins, FIFO 1
        tick();
        drive(1, 5'd23, 64'hA23, 1, 5'd24, 64'h124);   // ALU 23 wins, FIFO 2
        tick();
        check("pre_reset_count", {62'd0, o_mem_count}, 64'd2);
        check("pre_reset_mem_ready", {63'd0, o_mem_ready}, 64'd0);
        drive(1, 5'd25, 64'hA25, 0, 0, 64'h0);
        i_arst_n = 1'b0;
        #1;
        check("mid_rst_we",        {63'd0, o_write_en_3}, 64'd0);
        check("mid_rst_count",     {62'd0, o_mem_count}, 64'd0);
        check("mid_rst_mem_ready", {63'd0, o_mem_ready}, 64'd1);
        check("mid_rst_alu_ready", {63'd0, o_alu_ready}, 64'd0);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 0, 64'h0);
        i_arst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("post_rst_idle%0d_we", c), {63'd0, o_write_en_3}, 64'd0);
            check($sformatf("post_rst_idle%0d_count", c), {62'd0, o_mem_count}, 64'd0);
        end

        // fresh ALU write after reset
        drive(1, 5'd6, 64'hA06, 0, 0, 64'h0);
        #1;
        check("post_rst_alu_ready", {63'd0, o_alu_ready}, 64'd1);
        tick();
        check("post_rst_we",   {63'd0, o_write_en_3}, 64'd1);
        check("post_rst_addr", {59'd0, o_addr_3}, 64'd6);
        check("post_rst_data", o_write_data_3, 64'hA06);
        drive(0, 0, 64'h0, 0, 0, 64'h0);
        tick();
        @(negedge clk);
        #1;
        check("sb_queue_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
